// File: rtl/divisor_counter.sv
// rtl/divisor_counter.sv - counts the positive divisors of n by trial division up to sqrt(n)
module divisor_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, TEST, DIV, ACC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    bit_cnt;
  logic             sq_eq;

  logic [2*WIDTH-1:0] d_wide;
  logic [2*WIDTH-1:0] n_wide;
  logic [2*WIDTH-1:0] sq;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_sub;
  logic               fits;

  always_comb begin
    d_wide    = (2*WIDTH)'(d);
    n_wide    = (2*WIDTH)'(n);
    sq        = d_wide * d_wide;
    rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    fits      = rem_shift >= {1'b0, dvs};
    rem_sub   = rem_shift - {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      n       <= '0;
      d       <= '0;
      count   <= '0;
      quo     <= '0;
      dvs     <= '0;
      rem     <= '0;
      bit_cnt <= '0;
      sq_eq   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n     <= value;
            d     <= WIDTH'(1);
            count <= '0;
            state <= TEST;
          end
        end
        TEST: begin
          if (!start) begin
            state <= IDLE;
          end else if (sq > n_wide) begin
            result <= count;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            // restoring divider: quotient bits shift into quo as dividend bits shift out
            quo     <= n;
            dvs     <= d;
            rem     <= '0;
            bit_cnt <= '0;
            sq_eq   <= (sq == n_wide);
            state   <= DIV;
          end
        end
        DIV: begin
          if (!start) begin
            state <= IDLE;
          end else begin
            rem     <= fits ? rem_sub : rem_shift;
            quo     <= {quo[WIDTH-2:0], fits};
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(WIDTH-1)) state <= ACC;
          end
        end
        ACC: begin
          if (!start) begin
            state <= IDLE;
          end else begin
            // d and n/d are distinct divisors unless d is the exact square root
            if (rem == '0) count <= count + (sq_eq ? WIDTH'(1) : WIDTH'(2));
            d     <= d + WIDTH'(1);
            state <= TEST;
          end
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_counter.sv
// tb/tb_divisor_counter.sv - directed and random requests against a trial-division reference model
module tb_divisor_counter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] value;
  logic [W-1:0] result;
  logic         done;

  int errors = 0;
  int checks = 0;

  divisor_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int unsigned ref_divisors(input int unsigned n);
    int unsigned c = 0;
    for (int unsigned i = 1; i <= n; i++)
      if (n % i == 0) c++;
    return c;
  endfunction

  function automatic int unsigned ref_isqrt(input int unsigned n);
    int unsigned t = 0;
    while ((t + 1) * (t + 1) <= n) t++;
    return t;
  endfunction

  function automatic int unsigned ref_latency(input int unsigned n);
    return (W + 2) * ref_isqrt(n) + 2;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // counts edges from the capture edge until done is seen high
  task automatic wait_done(output int edges);
    edges = 0;
    while (!done && edges < 5000) begin
      @(posedge clk);
      edges++;
      #1;
    end
  endtask

  task automatic request(input string tag, input int unsigned v);
    int edges;
    @(negedge clk);
    value = v;
    start = 1'b1;
    wait_done(edges);
    check({tag, "_latency"}, 64'(edges), 64'(ref_latency(v)));
    check({tag, "_result"}, 64'(result), 64'(ref_divisors(v)));
  endtask

  task automatic release_req(input string tag, input int unsigned v);
    @(negedge clk);
    value = $urandom;
    @(negedge clk);
    check({tag, "_hold_done"}, 64'(done), 64'd1);
    check({tag, "_hold_result"}, 64'(result), 64'(ref_divisors(v)));
    start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_done_fall"}, 64'(done), 64'd0);
    check({tag, "_result_kept"}, 64'(result), 64'(ref_divisors(v)));
  endtask

  initial begin
    int unsigned v;
    int edges;
    logic saw_done;

    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    #1;
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_done", 64'(done), 64'd0);

    request("v28", 28);
    release_req("v28", 28);
    request("v36", 36);
    release_req("v36", 36);
    request("v0", 0);
    release_req("v0", 0);
    request("v1", 1);
    release_req("v1", 1);

    for (int k = 0; k < 8; k++) begin
      v = $urandom_range(400, 2);
      request("rand", v);
      release_req("rand", v);
    end

    request("b2b_first", 28);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("b2b_done_low", 64'(done), 64'd0);
    value = 12;
    start = 1'b1;
    wait_done(edges);
    check("b2b_latency", 64'(edges), 64'(ref_latency(12)));
    check("b2b_result", 64'(result), 64'(ref_divisors(12)));
    release_req("b2b", 12);

    @(negedge clk);
    value = 100;
    start = 1'b1;
    saw_done = 1'b0;
    repeat (49) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("abort_no_pulse", 64'(saw_done | done), 64'd0);
    check("abort_result_kept", 64'(result), 64'(ref_divisors(12)));
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_done", 64'(done), 64'd0);
    request("after_abort", 10);
    release_req("after_abort", 10);

    @(negedge clk);
    value = 1000;
    start = 1'b1;
    repeat (100) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_done", 64'(done), 64'd0);
    check("async_rst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_done(edges);
    check("post_rst_latency", 64'(edges), 64'(ref_latency(1000)));
    check("post_rst_result", 64'(result), 64'(ref_divisors(1000)));
    release_req("post_rst", 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
